// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RV32M multiply/divide unit feeding a register file write port.
// Ports: clk/reset (async, active-high); start_i/ready_o handshake with funct3_i, a_i, b_i, rd_i;
// abort_i kills an in-flight op; busy_o in CALC/DONE; wb_we_o/wb_rd_o/wb_data_o write-back strobe.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       rd_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             wb_we_o,
    output logic [4:0]       wb_rd_o,
    output logic [WIDTH-1:0] wb_data_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [2:0]         op;
    logic [4:0]         rd;
    logic               neg;
    logic [CW-1:0]      cnt;
    // multiply: multiplicand; divide: divisor
    logic [WIDTH-1:0]   m;
    // multiply: {partial high, remaining multiplier}; divide: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] acc;

    logic               accept, sgn_a, sgn_b, div0, ovf, special, last;
    logic [WIDTH-1:0]   abs_a, abs_b, spec_res, pick, fin;
    logic [WIDTH:0]     mul_sum, rs, diff;
    logic [2*WIDTH-1:0] step, prod;

    assign accept   = state == IDLE && start_i && !abort_i;
    assign sgn_a    = a_i[WIDTH-1] && (funct3_i == 3'b001 || funct3_i == 3'b010 ||
                                       funct3_i == 3'b100 || funct3_i == 3'b110);
    assign sgn_b    = b_i[WIDTH-1] && (funct3_i == 3'b001 || funct3_i == 3'b100 ||
                                       funct3_i == 3'b110);
    assign abs_a    = sgn_a ? -a_i : a_i;
    assign abs_b    = sgn_b ? -b_i : b_i;
    assign div0     = funct3_i[2] && b_i == '0;
    assign ovf      = funct3_i[2] && !funct3_i[0] && a_i == MIN && b_i == ONES;
    assign special  = div0 || ovf;
    assign spec_res = div0 ? (funct3_i[1] ? a_i : ONES) : (funct3_i[1] ? '0 : MIN);

    assign last     = cnt == CW'(WIDTH - 1);
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : '0};
    assign rs       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff     = rs - {1'b0, m};
    assign step     = op[2] ? (diff[WIDTH] ? {rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                           : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                            : {mul_sum, acc[WIDTH-1:1]};
    // product sign is applied to the full double-width value before the high half is taken
    assign prod     = neg ? -step : step;
    assign pick     = op[1] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    assign fin      = op[2] ? (neg ? -pick : pick)
                            : (op[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = accept ? (special ? DONE : CALC) : IDLE;
            CALC:    state_next = abort_i ? IDLE : (last ? DONE : CALC);
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = state == IDLE;
        busy_o  = state == CALC || state == DONE;
        wb_we_o = state == DONE && rd != 5'd0 && !abort_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op        <= '0;
            rd        <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            m         <= '0;
            acc       <= '0;
            wb_rd_o   <= '0;
            wb_data_o <= '0;
        end else if (accept) begin
            op  <= funct3_i;
            rd  <= rd_i;
            neg <= (funct3_i[2] && funct3_i[1]) ? sgn_a : sgn_a ^ sgn_b;
            cnt <= '0;
            m   <= funct3_i[2] ? abs_b : abs_a;
            acc <= {{WIDTH{1'b0}}, funct3_i[2] ? abs_a : abs_b};
            if (special) begin
                wb_rd_o   <= rd_i;
                wb_data_o <= spec_res;
            end
        end else if (state == CALC && !abort_i) begin
            acc <= step;
            cnt <= cnt + CW'(1);
            if (last) begin
                wb_rd_o   <= rd;
                wb_data_o <= fin;
            end
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: randomized and directed checks of mdu_iterative against an arithmetic reference model.
module tb_mdu_iterative;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] MIN  = 32'h8000_0000;

    logic        clk = 0;
    logic        reset = 1;
    logic        start_i = 0;
    logic [2:0]  funct3_i = 0;
    logic [31:0] a_i = 0;
    logic [31:0] b_i = 0;
    logic [4:0]  rd_i = 0;
    logic        abort_i = 0;
    logic        ready_o, busy_o, wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int total = 0;
    int bad = 0;

    mdu_iterative #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
        .a_i(a_i), .b_i(b_i), .rd_i(rd_i), .abort_i(abort_i),
        .ready_o(ready_o), .busy_o(busy_o), .wb_we_o(wb_we_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int x, y;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        x = a;
        y = b;
        p = (op == 3'd1) ? sa * sb : (op == 3'd2) ? sa * ub : ua * ub;
        case (op)
            3'd0:    r = p[31:0];
            3'd4:    r = (b == 0) ? ONES : (a == MIN && b == ONES) ? MIN : 32'(x / y);
            3'd5:    r = (b == 0) ? ONES : a / b;
            3'd6:    r = (b == 0) ? a : (a == MIN && b == ONES) ? 32'd0 : 32'(x % y);
            3'd7:    r = (b == 0) ? a : a % b;
            default: r = p[63:32];
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op[2] && b == 0) || ((op == 3'd4 || op == 3'd6) && a == MIN && b == ONES);
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return ONES;
            3:       return MIN;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op and follows it until ready_o returns; noise pokes start_i while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit noise, input string tag);
        logic [31:0] exp, got_d;
        logic [4:0]  got_rd;
        int lat, pulses, wcyc, rcyc;
        exp = model(op, a, b);
        lat = is_special(op, a, b) ? 1 : 33;
        @(negedge clk);
        start_i = 1; funct3_i = op; a_i = a; b_i = b; rd_i = rd;
        @(posedge clk); #1;
        start_i = 0; a_i = $urandom; b_i = $urandom; rd_i = 5'($urandom);
        pulses = 0; wcyc = 0; rcyc = 0; got_d = 0; got_rd = 0;
        for (int n = 1; n <= 40 && rcyc == 0; n++) begin
            if (wb_we_o) begin
                pulses++; wcyc = n; got_d = wb_data_o; got_rd = wb_rd_o;
            end
            if (ready_o) rcyc = n;
            if (noise) begin
                start_i = n < lat; funct3_i = 3'($urandom); rd_i = 5'($urandom);
            end
            if (rcyc == 0) begin
                @(posedge clk); #1;
            end
        end
        start_i = 0;
        check({tag, "_ready_cycle"}, rcyc, lat + 1);
        check({tag, "_pulses"}, pulses, 64'(rd != 0));
        if (rd != 0) begin
            check({tag, "_latency"}, wcyc, lat);
            check({tag, "_rd"}, got_rd, rd);
            check({tag, "_data"}, got_d, exp);
        end
    endtask

    task automatic watch_quiet(input string tag);
        int pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (wb_we_o) pulses++;
        end
        check({tag, "_no_strobe"}, pulses, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_data", wb_data_o, 0);
        @(negedge clk);
        reset = 0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, "mul");
        run_op(3'd1, MIN, MIN, 5'd6, 0, "mulh");
        run_op(3'd3, ONES, ONES, 5'd7, 0, "mulhu");
        run_op(3'd2, ONES, ONES, 5'd8, 0, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 0, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 0, "rem");
        run_op(3'd5, 32'd100, 32'd7, 5'd11, 0, "divu");
        run_op(3'd7, 32'd100, 32'd7, 5'd12, 0, "remu");
        run_op(3'd5, 32'd100, 32'd0, 5'd13, 0, "divu0");
        run_op(3'd6, 32'd100, 32'd0, 5'd14, 0, "rem0");
        run_op(3'd4, MIN, ONES, 5'd15, 0, "div_ovf");
        run_op(3'd6, MIN, ONES, 5'd16, 0, "rem_ovf");
        run_op(3'd0, 32'd3, 32'd4, 5'd0, 0, "rd0");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd17, 1, "busy_start");

        // abort in IDLE blocks acceptance
        @(negedge clk);
        start_i = 1; abort_i = 1; funct3_i = 3'd0; a_i = 5; b_i = 5; rd_i = 5'd3;
        @(posedge clk); #1;
        check("abort_idle_ready", ready_o, 1);
        start_i = 0; abort_i = 0;
        watch_quiet("abort_idle");

        // abort at CALC cycle 10
        @(negedge clk);
        start_i = 1; funct3_i = 3'd5; a_i = 32'd1000; b_i = 32'd3; rd_i = 5'd4;
        @(posedge clk); #1;
        start_i = 0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("abort_calc_busy", busy_o, 1);
        abort_i = 1;
        @(posedge clk); #1;
        abort_i = 0;
        check("abort_calc_ready", ready_o, 1);
        check("abort_calc_busy_off", busy_o, 0);
        watch_quiet("abort_calc");

        // asynchronous reset mid-CALC
        @(negedge clk);
        start_i = 1; funct3_i = 3'd0; a_i = 32'd9; b_i = 32'd9; rd_i = 5'd5;
        @(posedge clk); #1;
        start_i = 0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1;
        #1;
        check("async_rst_ready", ready_o, 1);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_we", wb_we_o, 0);
        check("async_rst_data", wb_data_o, 0);
        check("async_rst_rd", wb_rd_o, 0);
        @(negedge clk);
        reset = 0;
        watch_quiet("async_rst");

        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            op = 3'($urandom);
            run_op(op, pick_val(), pick_val(), 5'($urandom), bit'($urandom_range(0, 1)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
